sram_banked_dp: RTL
===================

Name: sram_banked_dp

Overview:
- Parametrised dual-port word SRAM. Built from depth-wise banks; each bank is DATA_W/8 byte lanes of 2048x8 dual-port block RAM.
- Generalises the fixed 2048x32 byte-banked wrapper: configurable width and depth, address decode across banks, per-port request/valid handshake, collision arbitration and an out-of-range error flag.
- Sits between accelerator/DMA ports and on-chip storage in the ESP tile.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 16, width of the word-address port.
- BANK_DEPTH, 2048, words per bank; must be a power of 2.
- NUM_BANKS, 4, number of depth-wise banks; must be a power of 2. Total depth = NUM_BANKS*BANK_DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- en0  in  1  port-0 request
- wea0  in  DATA_W/8  port-0 byte write enables; all-zero means read
- addr0  in  ADDR_W  port-0 word address
- wdata0  in  DATA_W  port-0 write data
- rdata0  out  DATA_W  port-0 read data
- rvalid0  out  1  port-0 read data valid
- err0  out  1  port-0 out-of-range pulse
- en1, wea1, addr1, wdata1, rdata1, rvalid1, err1: identical for port 1

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous, active-high. While rst is high, rdata*=0, rvalid*=0, err*=0 and all pipeline registers clear. Memory contents are not reset.
- Address split: bank index = addr[log2(BANK_DEPTH)+:log2(NUM_BANKS)], row = addr[log2(BANK_DEPTH)-1:0].
- Out of range: address >= NUM_BANKS*BANK_DEPTH, i.e. any set upper bit.
  - No write, no bank access.
  - err pulses 1 cycle, one cycle after the request.
  - If it was a read, rvalid also pulses with rdata=0.
- Read (en=1, wea=0): rdata and rvalid appear 1 cycle after the request, with rvalid high for exactly 1 cycle.
  - Bank select is registered alongside the request for the output mux.
  - Back-to-back reads give 1 result per cycle.
- rdata holds its last value until the next rvalid.
- Write (en=1, wea!=0): each byte lane is written where wea[i]=1. No rvalid is produced.
- Mixed wea with read: a write never returns data.
- Same-port read-during-write is not possible, because wea!=0 means write.
- Cross-port, same address:
  - Both write: port 0 wins on every byte lane where wea0 is set; port-1 bytes are written only where wea0[i]=0.
  - One reads, one writes: the read returns the OLD data (read-first).
  - Both read: both get the same data.
- Different banks: fully concurrent, no stalls. The block never back-pressures.
- rst asserted mid-operation: in-flight rvalid/err are dropped. A write in the reset-assertion cycle is not guaranteed.
- en=0: no access, outputs hold, rvalid=0.

Optional Feature:
- Macro SRAM_OUT_REG_EN.
- Defined: an extra output register stage is added on rdata/rvalid/err. Read latency becomes 2 cycles, throughput is unchanged, and reset clears the stage.
- Undefined: latency is 1 cycle as above.

Decomposition:
- Package sram_pkg holds:
  - the BYTE_W=8 constant;
  - functions clog2-based BANK_AW(BANK_DEPTH) and BANK_SW(NUM_BANKS);
  - typedef sram_req_t {en, wea, addr, wdata}.
- Sub-module sram_byte_bank_dp: one BANK_DEPTH x 8 dual-port, read-first RAM with write-enable per port.
  - Generated NUM_BANKS*DATA_W/8 times.
  - Top level holds decode, collision masking, the registered bank-select/valid pipeline and the output mux.

Test Plan:
- Reset: assert rst mid-stream with rvalid0 high -> rdata0=0, rvalid0=0 and err0=0 immediately (async), and they stay 0 until the next read after release.
- Byte write then read:
  - Write addr0=0x0005, wdata0=0xDEADBEEF, wea0=4'b1111.
  - Then write wea0=4'b0010, wdata0=0x0000AA00.
  - Then read addr0=0x0005 -> after 1 cycle rdata0=0xDEADAAEF with a 1-cycle rvalid0 (2 cycles with SRAM_OUT_REG_EN).
- Bank decode: write 0x11111111 to addr 0x0000 and 0x22222222 to addr 0x0800; read both back to back -> 0x11111111 then 0x22222222 on consecutive cycles.
- Dual-write collision:
  - Same cycle: port0 writes 0xAAAAAAAA with wea0=4'b0011; port1 writes 0xBBBBBBBB with wea1=4'b1111; both at addr 0x0010, initially 0.
  - A later read returns 0xBBBBAAAA.
- Read-first: addr 0x0020 holds 0x12345678. Port1 reads while port0 writes 0x0 in the same cycle -> rdata1=0x12345678; the next read returns 0x00000000.
- Out of range: read addr1=0x2000 with default params -> err1=1 and rvalid1=1 with rdata1=0 for 1 cycle, and memory is unchanged.

Source files
------------

// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared constants, sizing helpers and the request record used by the
// banked dual-port SRAM (sram_banked_dp) and its byte-bank primitive.
//   BYTE_W      : width of one byte lane
//   BANK_AW()   : row-address width of a bank for a given bank depth
//   BANK_SW()   : bank-select width for a given bank count (min 1 bit)
//   sram_req_t  : one port's request {en, wea, addr, wdata}; fields are sized
//                 for the widest supported configuration and narrowed by the
//                 user of the record.
// ---------------------------------------------------------------------------
package sram_pkg;

  localparam int BYTE_W        = 8;
  localparam int REQ_ADDR_MAX  = 32;
  localparam int REQ_DATA_MAX  = 256;
  localparam int REQ_BYTES_MAX = REQ_DATA_MAX / BYTE_W;

  function automatic int BANK_AW(input int bank_depth);
    return (bank_depth > 1) ? $clog2(bank_depth) : 1;
  endfunction

  // A single bank still needs a 1-bit select vector; it is masked to 0.
  function automatic int BANK_SW(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  typedef struct packed {
    logic                     en;
    logic [REQ_BYTES_MAX-1:0] wea;
    logic [REQ_ADDR_MAX-1:0]  addr;
    logic [REQ_DATA_MAX-1:0]  wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_byte_bank_dp.sv
// ---------------------------------------------------------------------------
// sram_byte_bank_dp
// One DEPTH x 8 true dual-port, read-first block RAM lane.
//   clk            : clock
//   re0/re1        : port read enable; the read register updates only on a
//                    read so it keeps the last word read
//   we0/we1        : port write enable
//   addr0/addr1    : row address (AW bits)
//   wdata0/wdata1  : write byte
//   rdata0/rdata1  : registered read byte (old contents on same-row write)
// Contents are never reset. The parent masks port-1 writes that collide
// with port 0, so the write order below never decides a result.
// ---------------------------------------------------------------------------
module sram_byte_bank_dp
  import sram_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic              clk,
  input  logic              re0,
  input  logic              we0,
  input  logic [AW-1:0]     addr0,
  input  logic [BYTE_W-1:0] wdata0,
  output logic [BYTE_W-1:0] rdata0,
  input  logic              re1,
  input  logic              we1,
  input  logic [AW-1:0]     addr1,
  input  logic [BYTE_W-1:0] wdata1,
  output logic [BYTE_W-1:0] rdata1
);

  logic [BYTE_W-1:0] mem [0:DEPTH-1];
  logic [BYTE_W-1:0] rdata0_q;
  logic [BYTE_W-1:0] rdata1_q;

  always_ff @(posedge clk) begin
    if (re0) rdata0_q <= mem[addr0];
    if (re1) rdata1_q <= mem[addr1];
    if (we1) mem[addr1] <= wdata1;
    if (we0) mem[addr0] <= wdata0;
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: rtl/sram_banked_dp.sv
// ---------------------------------------------------------------------------
// sram_banked_dp
// Dual-port word SRAM built from NUM_BANKS depth-wise banks, each bank made
// of DATA_W/8 byte lanes of BANK_DEPTH x 8 dual-port RAM.
//   clk, rst                : clock, asynchronous active-high reset
//   en*, wea*, addr*, wdata*: port request; wea all-zero means read
//   rdata*, rvalid*         : read data and its 1-cycle valid
//   err*                    : 1-cycle pulse for an out-of-range request
// Port 0 wins byte lanes on a same-address dual write; reads are read-first.
// Optional macro SRAM_OUT_REG_EN adds one output register stage on
// rdata/rvalid/err (read latency 2, same throughput).
// ---------------------------------------------------------------------------
module sram_banked_dp
  import sram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int BANK_DEPTH = 2048,
  parameter int NUM_BANKS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en0,
  input  logic [DATA_W/8-1:0] wea0,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [DATA_W-1:0]   wdata0,
  output logic [DATA_W-1:0]   rdata0,
  output logic                rvalid0,
  output logic                err0,
  input  logic                en1,
  input  logic [DATA_W/8-1:0] wea1,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata1,
  output logic [DATA_W-1:0]   rdata1,
  output logic                rvalid1,
  output logic                err1
);

  localparam int NBYTES  = DATA_W / BYTE_W;
  localparam int AW      = BANK_AW(BANK_DEPTH);
  localparam int SW      = BANK_SW(NUM_BANKS);
  localparam int USED_AW = AW + $clog2(NUM_BANKS);

  sram_req_t req [2];

  always_comb begin
    req[0]       = '0;
    req[1]       = '0;
    req[0].en    = en0;
    req[0].wea   = REQ_BYTES_MAX'(wea0);
    req[0].addr  = REQ_ADDR_MAX'(addr0);
    req[0].wdata = REQ_DATA_MAX'(wdata0);
    req[1].en    = en1;
    req[1].wea   = REQ_BYTES_MAX'(wea1);
    req[1].addr  = REQ_ADDR_MAX'(addr1);
    req[1].wdata = REQ_DATA_MAX'(wdata1);
  end

  // Upper padding bits of the record are intentionally dropped.
  logic unused_req;
  assign unused_req = ^{req[0], req[1]};

  // ---------------- per-port decode ----------------
  logic              en_p    [2];
  logic [NBYTES-1:0] wea_p   [2];
  logic [ADDR_W-1:0] addr_p  [2];
  logic [DATA_W-1:0] wdata_p [2];
  logic              oor     [2];
  logic              rd_req  [2];
  logic              rd_ok   [2];
  logic [SW-1:0]     bank    [2];
  logic [AW-1:0]     row     [2];

  for (genvar gp = 0; gp < 2; gp++) begin : g_port
    assign en_p[gp]    = req[gp].en;
    assign wea_p[gp]   = NBYTES'(req[gp].wea);
    assign addr_p[gp]  = ADDR_W'(req[gp].addr);
    assign wdata_p[gp] = DATA_W'(req[gp].wdata);
    // Any address bit above the bank-select field means out of range.
    assign oor[gp]     = (addr_p[gp] >> USED_AW) != '0;
    assign bank[gp]    = SW'(addr_p[gp] >> AW) & SW'(NUM_BANKS - 1);
    assign row[gp]     = AW'(addr_p[gp]);
    assign rd_req[gp]  = en_p[gp] && (wea_p[gp] == '0);
    assign rd_ok[gp]   = rd_req[gp] && !oor[gp];
  end

  // Port-1 byte lanes lose to port-0 lanes on a same-address collision.
  logic              same_addr;
  logic [NBYTES-1:0] wea_eff [2];

  always_comb begin
    same_addr  = en_p[0] && en_p[1] && !oor[0] && (addr_p[0] == addr_p[1]);
    wea_eff[0] = wea_p[0];
    wea_eff[1] = same_addr ? (wea_p[1] & ~wea_p[0]) : wea_p[1];
  end

  // ---------------- bank array ----------------
  logic [1:0][NUM_BANKS-1:0][DATA_W-1:0] bank_word;

  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    logic sel0;
    logic sel1;
    assign sel0 = en_p[0] && !oor[0] && (bank[0] == SW'(gb));
    assign sel1 = en_p[1] && !oor[1] && (bank[1] == SW'(gb));

    for (genvar gl = 0; gl < NBYTES; gl++) begin : g_lane
      logic [BYTE_W-1:0] q0;
      logic [BYTE_W-1:0] q1;

      sram_byte_bank_dp #(
        .DEPTH (BANK_DEPTH),
        .AW    (AW)
      ) u_ram (
        .clk    (clk),
        .re0    (sel0 && rd_req[0]),
        .we0    (sel0 && wea_eff[0][gl]),
        .addr0  (row[0]),
        .wdata0 (wdata_p[0][gl*BYTE_W +: BYTE_W]),
        .rdata0 (q0),
        .re1    (sel1 && rd_req[1]),
        .we1    (sel1 && wea_eff[1][gl]),
        .addr1  (row[1]),
        .wdata1 (wdata_p[1][gl*BYTE_W +: BYTE_W]),
        .rdata1 (q1)
      );

      assign bank_word[0][gb][gl*BYTE_W +: BYTE_W] = q0;
      assign bank_word[1][gb][gl*BYTE_W +: BYTE_W] = q1;
    end
  end

  // ---------------- request pipeline ----------------
  // zero_q forces rdata to 0 after reset or an out-of-range read, since the
  // RAM read registers themselves are not reset. bank_sel_q only moves on
  // an in-range read so rdata holds between valid results.
  logic [1:0]    rvalid_q, rvalid_d;
  logic [1:0]    err_q, err_d;
  logic [1:0]    zero_q, zero_d;
  logic [SW-1:0] bank_sel_q [2];
  logic [SW-1:0] bank_sel_d [2];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rvalid_d[p]   = rd_req[p];
      err_d[p]      = en_p[p] && oor[p];
      zero_d[p]     = zero_q[p];
      bank_sel_d[p] = bank_sel_q[p];
      if (rd_req[p]) begin
        zero_d[p] = oor[p];
        if (rd_ok[p]) bank_sel_d[p] = bank[p];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q      <= '0;
      err_q         <= '0;
      zero_q        <= '1;
      bank_sel_q[0] <= '0;
      bank_sel_q[1] <= '0;
    end else begin
      rvalid_q      <= rvalid_d;
      err_q         <= err_d;
      zero_q        <= zero_d;
      bank_sel_q[0] <= bank_sel_d[0];
      bank_sel_q[1] <= bank_sel_d[1];
    end
  end

  logic [DATA_W-1:0] rdata_s1 [2];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata_s1[p] = '0;
      if (!zero_q[p]) rdata_s1[p] = bank_word[p][bank_sel_q[p]];
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic [DATA_W-1:0] rdata_out_q [2];
  logic [DATA_W-1:0] rdata_out_d [2];
  logic [1:0]        rvalid_out_q, rvalid_out_d;
  logic [1:0]        err_out_q, err_out_d;

  always_comb begin
    rdata_out_d[0] = rdata_s1[0];
    rdata_out_d[1] = rdata_s1[1];
    rvalid_out_d   = rvalid_q;
    err_out_d      = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_out_q[0] <= '0;
      rdata_out_q[1] <= '0;
      rvalid_out_q   <= '0;
      err_out_q      <= '0;
    end else begin
      rdata_out_q[0] <= rdata_out_d[0];
      rdata_out_q[1] <= rdata_out_d[1];
      rvalid_out_q   <= rvalid_out_d;
      err_out_q      <= err_out_d;
    end
  end

  assign rdata0  = rdata_out_q[0];
  assign rdata1  = rdata_out_q[1];
  assign rvalid0 = rvalid_out_q[0];
  assign rvalid1 = rvalid_out_q[1];
  assign err0    = err_out_q[0];
  assign err1    = err_out_q[1];
`else
  assign rdata0  = rdata_s1[0];
  assign rdata1  = rdata_s1[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign err0    = err_q[0];
  assign err1    = err_q[1];
`endif

endmodule
